// File: rtl/redirect_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : redirect_arbiter_pkg
// Brief    : Shared widths, redirect source codes and arbiter state encodings.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package redirect_arbiter_pkg;

    localparam int C_ROBPTRW = 6;
    localparam int C_ADDRW   = 32;

    typedef enum logic [1:0] {
        SRC_BRU  = 2'b00,
        SRC_LSU  = 2'b01,
        SRC_CSRU = 2'b10
    } src_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAITHEAD = 2'b01,
        DRAIN    = 2'b10
    } state_e;

endpackage

`default_nettype wire

// File: rtl/redirect_arbiter_age_cmp.sv
//------------------------------------------------------------------------------
// Module   : rob_age_cmp
// Brief    : Combinational "a strictly older than b" for wrap-bit ROB pointers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rob_age_cmp
    import redirect_arbiter_pkg::*;
#(
    parameter int ROBPTRW = C_ROBPTRW
) (
    input  logic [ROBPTRW-1:0] i_a,
    input  logic [ROBPTRW-1:0] i_b,
    output logic               o_older
);

    logic w_same_wrap;

    assign w_same_wrap = (i_a[ROBPTRW-1] == i_b[ROBPTRW-1]);

    // Across a wrap the larger index was allocated first.
    always_comb begin
        if (w_same_wrap) begin
            o_older = (i_a[ROBPTRW-2:0] < i_b[ROBPTRW-2:0]);
        end else begin
            o_older = (i_a[ROBPTRW-2:0] > i_b[ROBPTRW-2:0]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/redirect_arbiter.sv
//------------------------------------------------------------------------------
// Module   : redirect_arbiter
// Brief    : Picks the oldest BRU/LSU/CSRU redirect, holds non-BRU ones until
//            ROB head, emits one registered redirect, then drains.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module redirect_arbiter
    import redirect_arbiter_pkg::*;
#(
    parameter int ROBPTRW  = C_ROBPTRW,
    parameter int ADDRW    = C_ADDRW,
    parameter int DRAINCYC = 4
) (
    input  logic               Clk,
    input  logic               Rest,
    input  logic               BruValid,
    input  logic [ROBPTRW-1:0] BruPtr,
    input  logic [ADDRW-1:0]   BruPc,
    input  logic               LsuValid,
    input  logic [ROBPTRW-1:0] LsuPtr,
    input  logic [ADDRW-1:0]   LsuPc,
    input  logic               CsruValid,
    input  logic [ROBPTRW-1:0] CsruPtr,
    input  logic [ADDRW-1:0]   CsruPc,
    input  logic [ROBPTRW-1:0] RobHeadPtr,
    input  logic               RobReLoad,
    output logic               OutRedirect,
    output logic [ROBPTRW-1:0] OutPtr,
    output logic [ADDRW-1:0]   OutPc,
    output logic [1:0]         OutSrc,
    output logic               Busy
);

    localparam int                C_CNTW     = $clog2(DRAINCYC + 1);
    localparam logic [C_CNTW-1:0] C_CNT_LOAD = C_CNTW'(DRAINCYC);
    localparam logic [C_CNTW-1:0] C_CNT_ONE  = C_CNTW'(1);

    state_e               r_state, w_state_n;
    logic [ROBPTRW-1:0]   r_held_ptr, w_held_ptr_n;
    logic [ADDRW-1:0]     r_held_pc, w_held_pc_n;
    logic [1:0]           r_held_src, w_held_src_n;
    logic [ROBPTRW-1:0]   r_kill_ptr, w_kill_ptr_n;
    logic [C_CNTW-1:0]    r_cnt, w_cnt_n;

    logic                 r_out_redirect;
    logic [ROBPTRW-1:0]   r_out_ptr;
    logic [ADDRW-1:0]     r_out_pc;
    logic [1:0]           r_out_src;
    logic                 r_busy;

    logic                 w_lsu_older_csru, w_bru_older_cl, w_in_older_ref;
    logic                 w_cl_valid, w_in_valid;
    logic [ROBPTRW-1:0]   w_cl_ptr, w_in_ptr, w_ref_ptr;
    logic [ADDRW-1:0]     w_cl_pc, w_in_pc;
    logic [1:0]           w_cl_src, w_in_src;

    logic                 w_emit;
    logic [ROBPTRW-1:0]   w_emit_ptr;
    logic [ADDRW-1:0]     w_emit_pc;
    logic [1:0]           w_emit_src;

    rob_age_cmp #(.ROBPTRW(ROBPTRW)) u_cmp_lsu_csru (
        .i_a     (LsuPtr),
        .i_b     (CsruPtr),
        .o_older (w_lsu_older_csru)
    );

    rob_age_cmp #(.ROBPTRW(ROBPTRW)) u_cmp_bru_cl (
        .i_a     (BruPtr),
        .i_b     (w_cl_ptr),
        .o_older (w_bru_older_cl)
    );

    rob_age_cmp #(.ROBPTRW(ROBPTRW)) u_cmp_in_ref (
        .i_a     (w_in_ptr),
        .i_b     (w_ref_ptr),
        .o_older (w_in_older_ref)
    );

    // Strict "older" compares give the CSRU > LSU > BRU tie-break for free.
    always_comb begin
        w_cl_valid = CsruValid | LsuValid;
        if (LsuValid && (!CsruValid || w_lsu_older_csru)) begin
            w_cl_ptr = LsuPtr;
            w_cl_pc  = LsuPc;
            w_cl_src = SRC_LSU;
        end else begin
            w_cl_ptr = CsruPtr;
            w_cl_pc  = CsruPc;
            w_cl_src = SRC_CSRU;
        end

        w_in_valid = w_cl_valid | BruValid;
        if (BruValid && (!w_cl_valid || w_bru_older_cl)) begin
            w_in_ptr = BruPtr;
            w_in_pc  = BruPc;
            w_in_src = SRC_BRU;
        end else begin
            w_in_ptr = w_cl_ptr;
            w_in_pc  = w_cl_pc;
            w_in_src = w_cl_src;
        end

        w_ref_ptr = (r_state == DRAIN) ? r_kill_ptr : r_held_ptr;
    end

    always_comb begin
        w_state_n    = r_state;
        w_held_ptr_n = r_held_ptr;
        w_held_pc_n  = r_held_pc;
        w_held_src_n = r_held_src;
        w_kill_ptr_n = r_kill_ptr;
        w_cnt_n      = r_cnt;
        w_emit       = 1'b0;
        w_emit_ptr   = w_in_ptr;
        w_emit_pc    = w_in_pc;
        w_emit_src   = w_in_src;

        if (RobReLoad) begin
            w_state_n    = IDLE;
            w_held_ptr_n = '0;
            w_held_pc_n  = '0;
            w_held_src_n = '0;
            w_kill_ptr_n = '0;
            w_cnt_n      = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_valid) begin
                        if (w_in_src == SRC_BRU) begin
                            w_emit       = 1'b1;
                            w_state_n    = DRAIN;
                            w_kill_ptr_n = w_in_ptr;
                            w_cnt_n      = C_CNT_LOAD;
                        end else begin
                            w_state_n    = WAITHEAD;
                            w_held_ptr_n = w_in_ptr;
                            w_held_pc_n  = w_in_pc;
                            w_held_src_n = w_in_src;
                        end
                    end
                end

                WAITHEAD: begin
                    if (w_in_valid && w_in_older_ref) begin
                        if (w_in_src == SRC_BRU) begin
                            w_emit       = 1'b1;
                            w_state_n    = DRAIN;
                            w_kill_ptr_n = w_in_ptr;
                            w_cnt_n      = C_CNT_LOAD;
                            w_held_ptr_n = '0;
                            w_held_pc_n  = '0;
                            w_held_src_n = '0;
                        end else begin
                            w_held_ptr_n = w_in_ptr;
                            w_held_pc_n  = w_in_pc;
                            w_held_src_n = w_in_src;
                        end
                    end
                    // Head match sees the entry after any same-cycle replacement.
                    if ((w_state_n == WAITHEAD) && (w_held_ptr_n == RobHeadPtr)) begin
                        w_emit       = 1'b1;
                        w_emit_ptr   = w_held_ptr_n;
                        w_emit_pc    = w_held_pc_n;
                        w_emit_src   = w_held_src_n;
                        w_state_n    = DRAIN;
                        w_kill_ptr_n = w_held_ptr_n;
                        w_cnt_n      = C_CNT_LOAD;
                        w_held_ptr_n = '0;
                        w_held_pc_n  = '0;
                        w_held_src_n = '0;
                    end
                end

                DRAIN: begin
                    if (w_in_valid && w_in_older_ref) begin
                        if (w_in_src == SRC_BRU) begin
                            w_emit       = 1'b1;
                            w_kill_ptr_n = w_in_ptr;
                            w_cnt_n      = C_CNT_LOAD;
                        end else begin
                            w_state_n    = WAITHEAD;
                            w_held_ptr_n = w_in_ptr;
                            w_held_pc_n  = w_in_pc;
                            w_held_src_n = w_in_src;
                            w_cnt_n      = '0;
                        end
                    end else if (r_cnt <= C_CNT_ONE) begin
                        w_state_n = IDLE;
                        w_cnt_n   = '0;
                    end else begin
                        w_cnt_n = r_cnt - C_CNT_ONE;
                    end
                end

                default: begin
                    w_state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_state        <= IDLE;
            r_held_ptr     <= '0;
            r_held_pc      <= '0;
            r_held_src     <= '0;
            r_kill_ptr     <= '0;
            r_cnt          <= '0;
            r_out_redirect <= 1'b0;
            r_out_ptr      <= '0;
            r_out_pc       <= '0;
            r_out_src      <= '0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_held_ptr     <= w_held_ptr_n;
            r_held_pc      <= w_held_pc_n;
            r_held_src     <= w_held_src_n;
            r_kill_ptr     <= w_kill_ptr_n;
            r_cnt          <= w_cnt_n;
            r_out_redirect <= w_emit;
            r_busy         <= (w_state_n != IDLE);
            if (w_emit) begin
                r_out_ptr <= w_emit_ptr;
                r_out_pc  <= w_emit_pc;
                r_out_src <= w_emit_src;
            end
        end
    end

    assign OutRedirect = r_out_redirect;
    assign OutPtr      = r_out_ptr;
    assign OutPc       = r_out_pc;
    assign OutSrc      = r_out_src;
    assign Busy        = r_busy;

endmodule

`default_nettype wire

// File: doc/redirect_arbiter.md
Name: redirect_arbiter

Overview:
- Collects BRU, LSU and CSRU redirect requests and selects the oldest by ROB pointer age.
- Holds LSU/CSRU redirects until their instruction reaches the ROB head.
- Emits one merged, registered redirect to the control block, then runs a drain window.
- During the drain window, younger redirects (already being cleaned) are suppressed.

Parameters:
- ROBPTRW, 6, ROB pointer width: MSB is the wrap bit, the low ROBPTRW-1 bits are the index.
- ADDRW, 32, instruction address width.
- DRAINCYC, 4, number of DRAIN cycles after each emitted redirect (≥1).

Ports:
- Clk  in  1  clock.
- Rest  in  1  asynchronous active-low reset.
- BruValid  in  1  branch mispredict request.
- BruPtr  in  ROBPTRW  ROB pointer of the mispredicted branch.
- BruPc  in  ADDRW  correct branch target.
- LsuValid  in  1  load/store replay request.
- LsuPtr  in  ROBPTRW  ROB pointer of the replayed instruction.
- LsuPc  in  ADDRW  replay PC.
- CsruValid  in  1  CSR/exception/ertn request.
- CsruPtr  in  ROBPTRW  ROB pointer of the CSR instruction.
- CsruPc  in  ADDRW  handler or return PC.
- RobHeadPtr  in  ROBPTRW  ROB head pointer.
- RobReLoad  in  1  full ROB flush; aborts the arbiter.
- OutRedirect  out  1  one-cycle redirect pulse.
- OutPtr  out  ROBPTRW  ROB pointer of the redirecting instruction.
- OutPc  out  ADDRW  redirect target.
- OutSrc  out  2  00 = BRU, 01 = LSU, 10 = CSRU.
- Busy  out  1  high in WAITHEAD or DRAIN.

Behaviour:
- Reset (async, Rest=0): state IDLE; OutRedirect=0, OutPtr=0, OutPc=0, OutSrc=0, Busy=0; drain counter 0; held entry cleared.
- Age compare, "a older than b":
  - same wrap bit: a.idx < b.idx;
  - different wrap bits: a.idx > b.idx.
  - Equal pointers tie-break CSRU > LSU > BRU.
- Candidate set each cycle = valid inputs plus the held entry (in WAITHEAD) or the kill pointer (in DRAIN). The winner is the oldest candidate.
- IDLE:
  - No valid input: stay IDLE.
  - BRU wins: register the output; OutRedirect=1 on the next cycle; go DRAIN with KillPtr=BruPtr and counter=DRAINCYC.
  - LSU or CSRU wins: latch {ptr, pc, src}; go WAITHEAD.
- WAITHEAD:
  - An input strictly older than the held entry replaces it, with the same BRU-emits / other-holds rule.
  - An input younger than or equal to the held entry is dropped.
  - When held ptr == RobHeadPtr: emit next cycle; go DRAIN with KillPtr=held ptr and counter=DRAINCYC.
  - The head match is checked after replacement in the same cycle.
- DRAIN:
  - Counter decrements each cycle; at 1 → IDLE on the next edge.
  - Inputs younger than or equal to KillPtr are dropped.
  - An input strictly older than KillPtr is handled as in IDLE: BRU emits and reloads the counter; LSU/CSRU goes to WAITHEAD.
- Emission latency: exactly 1 cycle from the deciding edge to OutRedirect=1. The pulse is one cycle wide. OutPtr/OutPc/OutSrc hold their values until the next emission.
- RobReLoad has highest priority in any state: next state IDLE, held entry cleared, counter cleared, no emission that cycle. A pulse already registered for this cycle still appears.
- Busy = (state != IDLE), registered.
- Simultaneous events:
  - Several inputs in one cycle are resolved purely by age plus the tie-break.
  - An input arriving in the same cycle as a head match is compared against the held entry first.

Decomposition:
- Shared package/define file: ROB pointer width, redirect source codes (SRC_BRU/SRC_LSU/SRC_CSRU), and state encodings IDLE/WAITHEAD/DRAIN.
- One natural sub-module, rob_age_cmp: a combinational older(a,b) with wrap handling, instantiated for the pairwise comparisons.

Test Plan:
- BRU alone: BruValid, BruPtr=6'h05, BruPc=32'h1c00_0100 in IDLE.
  - Required: OutRedirect=1 on the next cycle with OutSrc=00, OutPc=32'h1c00_0100.
  - Busy stays high for 4 cycles, then returns to IDLE.
- LSU waits for head: LsuPtr=6'h0A with RobHeadPtr=6'h08.
  - Required: no output.
  - When RobHeadPtr=6'h0A: OutRedirect pulse the next cycle with OutPtr=6'h0A, OutSrc=01.
- Wrap age: BruPtr=6'h22 and LsuPtr=6'h1E in the same cycle.
  - Required: LSU is older (1E); held in WAITHEAD, BRU dropped.
  - With BruPtr=6'h03 vs LsuPtr=6'h3E instead: LSU is older again.
- Tie: CsruPtr=LsuPtr=6'h10 together.
  - Required: CSRU is held; when the head reaches 10, OutSrc=10 with the CSRU PC.
- DRAIN filter: after a BRU emit with ptr 6'h07, BRU requests arrive during DRAIN.
  - BruPtr=6'h09: dropped.
  - BruPtr=6'h04: emitted next cycle and counter reloaded to 4.
- RobReLoad in WAITHEAD with an LSU request held.
  - Required: IDLE on the next cycle, Busy=0, no OutRedirect even when the head later matches.
  - Also: asserting Rest=0 mid-DRAIN clears all outputs immediately.
